// File: rtl/irq17_pkg.sv
// Shared definitions for the 17-source pending-interrupt encoder.
package irq17_pkg;

    localparam int NUM_SRC = 17;
    localparam int IDX_W   = 5;

    localparam logic [7:0] OVR_MAX = 8'hFF;

    // Offer handshake states: idle, offering one source, one-cycle gap after an ack.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        GAP  = 2'b10
    } irq_state_e;

    // Saturating 8-bit increment used by the overrun counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        logic [7:0] result;
        if (value == OVR_MAX) begin
            result = value;
        end else begin
            result = value + 8'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/irq_prio_enc17.sv
// Lowest-index-first priority encoder over a 17-bit request vector.
module irq_prio_enc17
    import irq17_pkg::*;
(
    input  logic [NUM_SRC-1:0] vec,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        found = 1'b0;
        idx   = {IDX_W{1'b0}};
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            found = found | vec[i];
            idx   = vec[i] ? IDX_W'(i) : idx;
        end
    end

endmodule

// File: rtl/irq_pending_encoder_17.sv
// Latches 17 request sources into a pending register, offers the lowest
// enabled pending source to the CPU, and clears it on acknowledge.
module irq_pending_encoder_17
    import irq17_pkg::*;
#(
    parameter logic [NUM_SRC-1:0] POLARITY_MASK = 17'h00000,
    parameter logic [NUM_SRC-1:0] EDGE_MASK     = 17'h00000
) (
    input  logic               GlobalClock,
    input  logic               Reset_n,
    input  logic [NUM_SRC-1:0] Src,
    input  logic [NUM_SRC-1:0] Enable_mask,
    output logic               Irq_any,
    output logic               Irq_req,
    output logic [IDX_W-1:0]   Irq_idx,
    input  logic               Irq_ack,
    output logic [NUM_SRC-1:0] Pending,
    output logic [7:0]         Overrun_cnt
);

    logic [NUM_SRC-1:0] s_real_s;
    logic [NUM_SRC-1:0] s_prev_r;
    logic [NUM_SRC-1:0] set_s;
    logic [NUM_SRC-1:0] clr_s;
    logic [NUM_SRC-1:0] pend_r;
    logic [NUM_SRC-1:0] pend_next_s;
    logic [NUM_SRC-1:0] sel_vec_s;
    logic               sel_found_s;
    logic [IDX_W-1:0]   sel_idx_s;
    logic               ovr_hit_s;
    irq_state_e         state_r;
    logic               req_r;
    logic [IDX_W-1:0]   idx_r;
    logic [7:0]         ovr_cnt_r;

    assign s_real_s  = Src ^ POLARITY_MASK;
    assign sel_vec_s = pend_r & Enable_mask;

    irq_prio_enc17 u_prio_enc (
        .vec   (sel_vec_s),
        .found (sel_found_s),
        .idx   (sel_idx_s)
    );

    // Per-bit set condition: rising edge for edge sources, asserted level otherwise.
    always_comb begin
        set_s = (EDGE_MASK & s_real_s & ~s_prev_r) | (~EDGE_MASK & s_real_s);
    end

    // One-hot clear of the offered source when the CPU acknowledges it.
    always_comb begin
        clr_s = {NUM_SRC{1'b0}};
        if ((state_r == REQ) && Irq_ack) begin
            clr_s = {{(NUM_SRC-1){1'b0}}, 1'b1} << idx_r;
        end else begin
            clr_s = {NUM_SRC{1'b0}};
        end
    end

    // Next pending value (set beats clear) and overrun detection on edge sources.
    always_comb begin
        pend_next_s = (pend_r & ~clr_s) | set_s;
        ovr_hit_s   = |(set_s & EDGE_MASK & pend_r & ~clr_s);
    end

    // Input history, pending bits and overrun counter.
    always_ff @(posedge GlobalClock or negedge Reset_n) begin
        if (!Reset_n) begin
            s_prev_r  <= {NUM_SRC{1'b0}};
            pend_r    <= {NUM_SRC{1'b0}};
            ovr_cnt_r <= 8'h00;
        end else begin
            s_prev_r <= s_real_s;
            pend_r   <= pend_next_s;
            if (ovr_hit_s) begin
                ovr_cnt_r <= sat_inc8(ovr_cnt_r);
            end else begin
                ovr_cnt_r <= ovr_cnt_r;
            end
        end
    end

    // Offer handshake: capture the winner in IDLE, hold it through REQ, one idle GAP after ack.
    always_ff @(posedge GlobalClock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r <= IDLE;
            req_r   <= 1'b0;
            idx_r   <= {IDX_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (sel_found_s) begin
                        state_r <= REQ;
                        req_r   <= 1'b1;
                        idx_r   <= sel_idx_s;
                    end else begin
                        state_r <= IDLE;
                        req_r   <= 1'b0;
                    end
                end
                REQ: begin
                    if (Irq_ack) begin
                        state_r <= GAP;
                        req_r   <= 1'b0;
                    end else begin
                        state_r <= REQ;
                        req_r   <= 1'b1;
                    end
                end
                GAP: begin
                    state_r <= IDLE;
                    req_r   <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    req_r   <= 1'b0;
                end
            endcase
        end
    end

    assign Irq_any     = sel_found_s;
    assign Irq_req     = req_r;
    assign Irq_idx     = idx_r;
    assign Pending     = pend_r;
    assign Overrun_cnt = ovr_cnt_r;

endmodule
